// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe
//   Pipelined binary-to-one-hot decoder with a 2-entry skid buffer.
//   The block keeps an accumulated busy mask of every one-hot bit it has
//   emitted since that bit was last cleared.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge) and asynchronous active-low reset
//   i_valid/o_ready  upstream handshake carrying i_data (index) and i_en
//   o_valid/i_ready  downstream handshake carrying o_data (one-hot mask)
//   i_clr_mask       per-bit clear of the busy mask
//   o_busy_mask      accumulated OR of transferred masks
//   o_collision      (only with ONEHOT_DEC_COLLISION_EN) registered pulse
//                    after a transfer that hits an already-busy bit
//
// Build option: define ONEHOT_DEC_COLLISION_EN to add o_collision.

module onehot_decoder_pipe #(
    parameter int unsigned  IDX_W = 3,
    localparam int unsigned OUT_W = 1 << IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IDX_W-1:0] i_data,
    input  logic             i_en,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    input  logic [OUT_W-1:0] i_clr_mask,
    output logic [OUT_W-1:0] o_busy_mask
`ifdef ONEHOT_DEC_COLLISION_EN
    ,
    output logic             o_collision
`endif
);

    // Output register (OREG) and skid register (SREG)
    logic             oreg_valid_q, oreg_valid_d;
    logic [OUT_W-1:0] oreg_data_q,  oreg_data_d;
    logic             sreg_valid_q, sreg_valid_d;
    logic [OUT_W-1:0] sreg_data_q,  sreg_data_d;
    logic [OUT_W-1:0] busy_q,       busy_d;

    logic             accept;
    logic             fire;
    logic [OUT_W-1:0] mask_in;

    // Ready comes straight from a flop, so it never depends on i_ready.
    assign o_ready = ~sreg_valid_q;
    assign accept  = i_valid & ~sreg_valid_q;
    assign fire    = oreg_valid_q & i_ready;

    always_comb begin
        mask_in = '0;
        if (i_en) begin
            mask_in[i_data] = 1'b1;
        end
    end

    always_comb begin
        oreg_valid_d = oreg_valid_q;
        oreg_data_d  = oreg_data_q;
        sreg_valid_d = sreg_valid_q;
        sreg_data_d  = sreg_data_q;
        if (!oreg_valid_q || fire) begin
            // OREG is free this cycle; the older skid entry has priority.
            // No accept can happen while SREG is full because o_ready is low.
            if (sreg_valid_q) begin
                oreg_valid_d = 1'b1;
                oreg_data_d  = sreg_data_q;
                sreg_valid_d = 1'b0;
            end else if (accept) begin
                oreg_valid_d = 1'b1;
                oreg_data_d  = mask_in;
            end else begin
                oreg_valid_d = 1'b0;
            end
        end else if (accept) begin
            sreg_valid_d = 1'b1;
            sreg_data_d  = mask_in;
        end
    end

    // Set wins over clear on the same bit.
    assign busy_d = (busy_q & ~i_clr_mask) | (fire ? oreg_data_q : '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            oreg_valid_q <= 1'b0;
            oreg_data_q  <= '0;
            sreg_valid_q <= 1'b0;
            sreg_data_q  <= '0;
            busy_q       <= '0;
        end else begin
            oreg_valid_q <= oreg_valid_d;
            oreg_data_q  <= oreg_data_d;
            sreg_valid_q <= sreg_valid_d;
            sreg_data_q  <= sreg_data_d;
            busy_q       <= busy_d;
        end
    end

    assign o_valid     = oreg_valid_q;
    assign o_data      = oreg_data_q;
    assign o_busy_mask = busy_q;

`ifdef ONEHOT_DEC_COLLISION_EN
    logic collision_q, collision_d;

    // Compare against the pre-update busy mask; a same-cycle clear of the
    // hit bit counts as a release, so no pulse.
    assign collision_d = fire & (|(oreg_data_q & busy_q & ~i_clr_mask));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign o_collision = collision_q;
`endif

endmodule

// File: doc/onehot_decoder_pipe.md
Name: onehot_decoder_pipe

Overview:
- Pipelined binary-to-one-hot decoder: the inverse of the one-hot-to-binary encoder used in the issue/select path.
- Accepts a stream of IDX_W-bit indices through a valid/ready handshake and emits registered one-hot masks downstream.
- Keeps an accumulated busy mask of every one-hot bit emitted since it was last cleared, for slot-allocation and scoreboard use in the 2-issue datapath.
- Includes a 2-entry skid buffer, so the upstream ready never depends combinationally on the downstream ready.

Parameters:
- IDX_W, 3, width of the binary index input.
- OUT_W, 2**IDX_W (derived, not overridable), width of the one-hot output and the busy mask.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream index valid.
- o_ready  output  1  block can accept an index this cycle.
- i_data  input  IDX_W  binary index.
- i_en  input  1  decode enable, sampled with i_data; 0 = emit all-zero mask.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts o_data.
- o_data  output  OUT_W  one-hot mask; bit i_data set when i_en=1.
- i_clr_mask  input  OUT_W  per-bit clear of the busy mask.
- o_busy_mask  output  OUT_W  accumulated OR of emitted masks.

Behaviour:
- Reset (async assert, sync deassert handled outside): o_valid=0, o_data=0, o_ready=1, o_busy_mask=0, skid entry empty. Reset mid-transfer drops all in-flight entries; nothing is replayed.
- Input handshake: accept when i_valid && o_ready. Output handshake: transfer when o_valid && i_ready.
- Decode: mask = i_en ? (1 << i_data) : 0, computed at accept time. Exactly one bit set when i_en=1, including i_data=0 (mask=1) and i_data=OUT_W-1 (MSB).
- Latency: an index accepted in cycle N appears on o_data with o_valid=1 in cycle N+1 when the output stage is empty or draining. Throughput is 1 per cycle while i_ready=1.
- Storage: output register (OREG) plus one skid register (SREG). o_ready is registered: o_ready = !SREG_valid.
- Accept while OREG is empty or draining: the entry loads OREG.
- Accept while OREG is full and not draining: the entry loads SREG, and o_ready falls next cycle.
- OREG drains while SREG is full: SREG moves to OREG, SREG empties, and o_ready rises next cycle.
- Same cycle as a drain, an accept with SREG empty: the new entry goes to OREG.
- Ordering: strict FIFO; the output order equals the accept order.
- No loss or duplication: no entry is dropped or duplicated under any i_valid/i_ready pattern.
- o_data is held stable while o_valid=1 && i_ready=0.
- Busy mask, updated every cycle: next = (busy & ~i_clr_mask) | (fire ? o_data : 0), where fire = o_valid && i_ready.
- Set/clear conflict: set wins when a clear and a set target the same bit in the same cycle.
- i_clr_mask may be nonzero in any cycle, including while idle.
- A zero mask (i_en=0) still counts as a transfer but leaves the busy mask unchanged.
- Re-emitting an already-busy bit is legal; the bit stays 1.

Optional Feature:
- Macro: ONEHOT_DEC_COLLISION_EN.
- Defined: adds port o_collision output 1.
  - o_collision is a registered pulse asserted the cycle after a transfer whose o_data & o_busy_mask (pre-update value) is nonzero, i.e. an allocation of an already-busy slot.
  - A same-cycle i_clr_mask of that bit suppresses the pulse.
  - Reset value 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then i_valid=1, i_data=3'd5, i_en=1, i_ready=1 -> next cycle o_valid=1, o_data=8'b0010_0000; the following cycle o_busy_mask=8'b0010_0000.
- Back-to-back indices 0..7 with i_ready=1 -> o_data=8'h01,02,04,…,80 on consecutive cycles; o_busy_mask=8'hFF after the last transfer; o_ready stays 1.
- Stall: i_ready=0 while indices 2,4,6 are offered -> 2 held on o_data=8'h04, 4 captured in SREG, o_ready=0, 6 not accepted. Release i_ready -> outputs 8'h04, 8'h10, 8'h40 in order; none lost or duplicated.
- i_en=0 with i_data=3'd7 -> o_data=8'h00, o_valid=1, o_busy_mask unchanged.
- Busy bit 3 set, then same cycle i_clr_mask=8'h08 and transfer of index 3 -> bit 3 remains 1. Next cycle i_clr_mask=8'h08 with no transfer -> bit 3 becomes 0.
- Assert i_rst_n=0 mid-stall with OREG and SREG full -> immediately o_valid=0, o_data=0, o_busy_mask=0, o_ready=1. With ONEHOT_DEC_COLLISION_EN, a second transfer of index 1 while busy bit 1 is set -> o_collision=1 for exactly one cycle.
